// File: rtl/ofm_pool_pkg.sv
// Shared constants and types for the OFM 2x2/stride-1 max-pooling stage.
package ofm_pool_pkg;
  localparam int DATA_W   = 36;
  localparam int OFM_DIM  = 5;
  localparam int POOL_DIM = OFM_DIM - 1;
  localparam int IDX_W    = $clog2(OFM_DIM);

  typedef enum logic {IDLE, RUN} state_e;
endpackage

// File: rtl/pool_max4.sv
// Combinational two-level unsigned max over a 2x2 window.
module pool_max4
  import ofm_pool_pkg::*;
#(
  parameter int W = DATA_W
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] c,
  input  logic [W-1:0] d,
  output logic [W-1:0] pool_max
);
  logic [W-1:0] max_ab, max_cd;

  assign max_ab   = (a > b) ? a : b;
  assign max_cd   = (c > d) ? c : d;
  assign pool_max = (max_ab > max_cd) ? max_ab : max_cd;
endmodule

// File: rtl/ofm_maxpool.sv
// Streaming 2x2 stride-1 max-pool over a raster-ordered OFM_DIM x OFM_DIM map.
// One-row line buffer; each pooled word is registered one cycle after its last input.
module ofm_maxpool
  import ofm_pool_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] In_OFM,
  output logic              out_valid,
  output logic [DATA_W-1:0] Out_Pool
);
  state_e            state;
  logic [IDX_W-1:0]  col, row;
  logic [DATA_W-1:0] row_buf [OFM_DIM];
  logic [DATA_W-1:0] prev_cur;
  logic [DATA_W-1:0] prev_top;
  logic [DATA_W-1:0] pool_max;
  logic              last_col, last_row, win_full;

  assign last_col = (col == IDX_W'(OFM_DIM - 1));
  assign last_row = (row == IDX_W'(OFM_DIM - 1));
  assign win_full = (row != '0) && (col != '0);

  // row_buf[col-1] already holds the current row by now, so the
  // previous-row top-left word is kept as a delayed copy in prev_top.
  pool_max4 #(.W(DATA_W)) u_max (
    .a        (prev_top),
    .b        (row_buf[col]),
    .c        (prev_cur),
    .d        (In_OFM),
    .pool_max (pool_max)
  );

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state     <= IDLE;
      col       <= '0;
      row       <= '0;
      prev_cur  <= '0;
      prev_top  <= '0;
      out_valid <= 1'b0;
      Out_Pool  <= '0;
      for (int i = 0; i < OFM_DIM; i++) row_buf[i] <= '0;
    end else begin
      out_valid <= 1'b0;
      Out_Pool  <= '0;
      if (in_valid) begin
        state        <= RUN;
        row_buf[col] <= In_OFM;
        prev_cur     <= In_OFM;
        prev_top     <= row_buf[col];
        if (win_full) begin
          out_valid <= 1'b1;
          Out_Pool  <= pool_max;
        end
        if (last_col) begin
          col <= '0;
          row <= last_row ? '0 : row + IDX_W'(1);
        end else begin
          col <= col + IDX_W'(1);
        end
      end else if (state == RUN) begin
        // End of stream or abort: drop any partial frame.
        state    <= IDLE;
        col      <= '0;
        row      <= '0;
        prev_cur <= '0;
        prev_top <= '0;
        for (int i = 0; i < OFM_DIM; i++) row_buf[i] <= '0;
      end
    end
  end
endmodule

// File: tb/tb_ofm_maxpool.sv
// Self-checking bench for ofm_maxpool: frame-level reference model plus directed scenarios.
module tb_ofm_maxpool;
  localparam int W = 36;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic [W-1:0] In_OFM = '0;
  logic         out_valid;
  logic [W-1:0] Out_Pool;

  ofm_maxpool dut (
    .clk       (clk),
    .rst_n     (rst),
    .in_valid  (in_valid),
    .In_OFM    (In_OFM),
    .out_valid (out_valid),
    .Out_Pool  (Out_Pool)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  function automatic void chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endfunction

  function automatic logic [W-1:0] max4(input logic [W-1:0] a, b, c, d);
    logic [W-1:0] m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

  // Reference: store the frame by raster index; the window of index k is
  // {k-6, k-5, k-1, k}, valid when row>=1 and col>=1.
  logic [W-1:0] mframe [25];
  int           midx;
  int           mr, mc;
  logic         mexp_v;
  logic [W-1:0] mexp_d;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      midx   = 0;
      mexp_v = 1'b0;
      mexp_d = '0;
    end else begin
      mexp_v = 1'b0;
      mexp_d = '0;
      if (in_valid) begin
        mr = midx / 5;
        mc = midx % 5;
        mframe[midx] = In_OFM;
        if (mr > 0 && mc > 0) begin
          mexp_v = 1'b1;
          mexp_d = max4(mframe[midx-6], mframe[midx-5], mframe[midx-1], In_OFM);
        end
        midx = (midx + 1) % 25;
      end else begin
        midx = 0;
      end
    end
  end

  logic [W-1:0] got [$];

  always @(negedge clk) begin
    chk("cyc_out_valid", out_valid, rst ? 1'b0 : mexp_v);
    chk("cyc_out_pool", Out_Pool, rst ? '0 : mexp_d);
    if (out_valid) got.push_back(Out_Pool);
  end

  logic [W-1:0] stim [64];
  logic [W-1:0] ramp_exp [16] = '{6,7,8,9,11,12,13,14,16,17,18,19,21,22,23,24};
  logic [W-1:0] desc_exp [16] = '{24,23,22,21,19,18,17,16,14,13,12,11,9,8,7,6};
  logic [W-1:0] ones;

  task automatic run_frame(input int n);
    got.delete();
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      In_OFM   = stim[i];
    end
    @(negedge clk);
    in_valid = 1'b0;
    In_OFM   = '0;
    repeat (3) @(negedge clk);
  endtask

  task automatic load_ramp(input int n, input int off);
    for (int i = 0; i < n; i++) stim[i] = W'((i % 25) + off + ((i >= 25) ? 100 - off : 0));
  endtask

  task automatic check_ramp(input string nm);
    chk({nm, "_cnt"}, W'(got.size()), W'(16));
    for (int i = 0; i < 16 && i < got.size(); i++) chk(nm, got[i], ramp_exp[i]);
  endtask

  initial begin
    logic [63:0] rnd;
    ones = '1;

    repeat (3) @(negedge clk);
    chk("reset_valid", out_valid, 1'b0);
    chk("reset_pool", Out_Pool, '0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // ramp
    load_ramp(25, 0);
    run_frame(25);
    check_ramp("ramp");

    // descending
    for (int i = 0; i < 25; i++) stim[i] = W'(24 - i);
    run_frame(25);
    chk("desc_cnt", W'(got.size()), W'(16));
    for (int i = 0; i < 16 && i < got.size(); i++) chk("desc", got[i], desc_exp[i]);

    // single full-scale spike at (2,2)
    for (int i = 0; i < 25; i++) stim[i] = '0;
    stim[12] = ones;
    run_frame(25);
    chk("spike_cnt", W'(got.size()), W'(16));
    for (int i = 0; i < 16 && i < got.size(); i++)
      chk("spike", got[i], (i == 5 || i == 6 || i == 9 || i == 10) ? ones : '0);

    // abort after 10 samples, then a clean frame
    load_ramp(25, 0);
    run_frame(10);
    chk("abort_cnt", W'(got.size()), W'(4));
    for (int i = 0; i < 4 && i < got.size(); i++) chk("abort", got[i], W'(6 + i));
    run_frame(25);
    check_ramp("post_abort");

    // back-to-back frames, second offset by 100
    load_ramp(50, 0);
    run_frame(50);
    chk("b2b_cnt", W'(got.size()), W'(32));
    for (int i = 0; i < 32 && i < got.size(); i++)
      chk("b2b", got[i], ramp_exp[i % 16] + ((i >= 16) ? W'(100) : W'(0)));

    // reset at sample 15
    load_ramp(25, 0);
    got.delete();
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      In_OFM   = stim[i];
    end
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("rst_mid_valid", out_valid, 1'b0);
    chk("rst_mid_pool", Out_Pool, '0);
    @(negedge clk);
    in_valid = 1'b0;
    In_OFM   = '0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run_frame(25);
    check_ramp("post_rst");

    // random traffic with occasional gaps, checked cycle by cycle
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      in_valid = ($urandom_range(0, 15) != 0);
      rnd = {$urandom, $urandom};
      In_OFM = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 3)) : rnd[W-1:0];
    end
    @(negedge clk);
    in_valid = 1'b0;
    In_OFM   = '0;
    repeat (4) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
